// File: rtl/serial_magnitude_comparator_if.sv
// Serial comparator bus: word framing, operand bits, per-word mode and the
// L/E/G result with busy/done status.
interface serial_magnitude_comparator_if;
  logic start;
  logic a;
  logic b;
  logic msb_first;
  logic signed_mode;
  logic L;
  logic E;
  logic G;
  logic busy;
  logic done;

  modport master (
    output start, a, b, msb_first, signed_mode,
    input  L, E, G, busy, done
  );

  modport slave (
    input  start, a, b, msb_first, signed_mode,
    output L, E, G, busy, done
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: WIDTH-bit words framed by start, LSB- or
// MSB-first, unsigned or two's complement, with registered one-hot L/E/G.
module serial_magnitude_comparator #(
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  serial_magnitude_comparator_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] RES_L = 3'b100;
  localparam logic [2:0] RES_E = 3'b010;
  localparam logic [2:0] RES_G = 3'b001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ord_q, ord_d;
  logic          sgn_q, sgn_d;
  logic [2:0]    res_q, res_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          ord_c;
  logic          sgn_c;
  logic [CW-1:0] idx_c;
  logic [2:0]    res_base;
  logic          at_sign;
  logic [2:0]    bit_res;
  logic [2:0]    res_eval;

  // A new word evaluates its first bit with the incoming mode and a fresh E.
  always_comb begin
    ord_c    = ord_q;
    sgn_c    = sgn_q;
    idx_c    = cnt_q;
    res_base = res_q;
    if (bus.start) begin
      ord_c    = bus.msb_first;
      sgn_c    = bus.signed_mode;
      idx_c    = '0;
      res_base = RES_E;
    end
    at_sign  = sgn_c && (ord_c ? (idx_c == '0) : (idx_c == LAST));
    bit_res  = (bus.a ^ at_sign) ? RES_G : RES_L;
    res_eval = res_base;
    if ((bus.a != bus.b) && (!ord_c || (res_base == RES_E))) begin
      res_eval = bit_res;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ord_d   = ord_q;
    sgn_d   = sgn_q;
    res_d   = res_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (bus.start) begin
      ord_d   = bus.msb_first;
      sgn_d   = bus.signed_mode;
      res_d   = res_eval;
      cnt_d   = CW'(1);
      state_d = SHIFT;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          res_d = res_eval;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ord_q   <= 1'b0;
      sgn_q   <= 1'b0;
      res_q   <= RES_E;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ord_q   <= ord_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.L    = res_q[2];
  assign bus.E    = res_q[1];
  assign bus.G    = res_q[0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomised and directed bench for the serial comparator at WIDTH=32 and 8,
// checked cycle by cycle against an arithmetic prefix-compare model.
module tb_serial_magnitude_comparator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_magnitude_comparator_if if32 ();
  serial_magnitude_comparator_if if8 ();

  serial_magnitude_comparator #(.WIDTH(32)) u_cmp32 (.clk(clk), .rst(rst), .bus(if32));
  serial_magnitude_comparator #(.WIDTH(8))  u_cmp8  (.clk(clk), .rst(rst), .bus(if8));

  localparam logic [2:0] F_L = 3'b100;
  localparam logic [2:0] F_E = 3'b010;
  localparam logic [2:0] F_G = 3'b001;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] held [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result after k+1 bits = plain comparison of the bits seen so far.
  function automatic logic [2:0] ref_flags(input logic [63:0] a, input logic [63:0] b,
                                           input int w, input bit ord, input bit sgn, input int k);
    logic [63:0] x, y;
    logic signed [63:0] sx, sy;
    bit use_sgn;
    if (ord) begin
      x = a << (64 - w);
      y = b << (64 - w);
      use_sgn = sgn;
    end else begin
      x = a << (63 - k);
      y = b << (63 - k);
      use_sgn = sgn && (k == w - 1);
    end
    if (use_sgn) begin
      sx = $signed(x) >>> (63 - k);
      sy = $signed(y) >>> (63 - k);
      return (sx < sy) ? F_L : (sx > sy) ? F_G : F_E;
    end
    x = x >> (63 - k);
    y = y >> (63 - k);
    return (x < y) ? F_L : (x > y) ? F_G : F_E;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic a, input logic b,
                       input logic ord, input logic sgn);
    if (sel) begin
      if8.start = st; if8.a = a; if8.b = b; if8.msb_first = ord; if8.signed_mode = sgn;
      if32.start = 1'b0;
    end else begin
      if32.start = st; if32.a = a; if32.b = b; if32.msb_first = ord; if32.signed_mode = sgn;
      if8.start = 1'b0;
    end
  endtask

  function automatic logic [2:0] flags(input bit sel);
    return sel ? {if8.L, if8.E, if8.G} : {if32.L, if32.E, if32.G};
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? if8.busy : if32.busy;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? if8.done : if32.done;
  endfunction

  // Sends nbits of a word (nbits < width means the word is cut short).
  task automatic send_word(input bit sel, input logic [63:0] A, input logic [63:0] B,
                           input bit ord, input bit sgn, input int nbits,
                           output logic [2:0] final_flags);
    int w;
    int pos;
    logic [2:0] exp;
    w = sel ? 8 : 32;
    final_flags = flags(sel);
    for (int k = 0; k < nbits; k++) begin
      pos = ord ? (w - 1 - k) : k;
      if (k == 0) drive(sel, 1'b1, A[pos], B[pos], ord, sgn);
      else drive(sel, 1'b0, A[pos], B[pos], 1'($urandom), 1'($urandom));
      @(posedge clk);
      @(negedge clk);
      exp = ref_flags(A, B, w, ord, sgn, k);
      check_eq("flags", 64'(flags(sel)), 64'(exp));
      check_eq("done", 64'(done_of(sel)), 64'(k == w - 1));
      check_eq("busy", 64'(busy_of(sel)), 64'(k < w - 1));
      final_flags = flags(sel);
      if (k == w - 1) held[sel] = exp;
    end
    $display("word w=%0d A=%0h B=%0h msb_first=%0d signed=%0d bits=%0d LEG=%b",
             w, A, B, ord, sgn, nbits, final_flags);
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      drive(sel, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_flags", 64'(flags(sel)), 64'(held[sel]));
      check_eq("idle_done", 64'(done_of(sel)), 64'd0);
      check_eq("idle_busy", 64'(busy_of(sel)), 64'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if32.start = 1'b1; if32.a = 1'($urandom); if32.b = 1'($urandom);
    if8.start = 1'b1;  if8.a = 1'($urandom);  if8.b = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if32.start = 1'b0;
    if8.start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check_eq("rst_flags", 64'(flags(1'(s))), 64'(F_E));
      check_eq("rst_busy", 64'(busy_of(1'(s))), 64'd0);
      check_eq("rst_done", 64'(done_of(1'(s))), 64'd0);
      held[s] = F_E;
    end
    $display("reset applied");
  endtask

  initial begin
    logic [2:0] f;
    logic [63:0] ra, rb;
    bit rsel, rord, rsgn;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset();

    send_word(1'b0, 64'hFFFFFFFF, 64'd123, 1'b0, 1'b0, 32, f); check_eq("u_lsb_G", 64'(f), 64'(F_G));
    idle(1'b0, 2);
    send_word(1'b0, 64'hFFFFFFFF, 64'd123, 1'b0, 1'b1, 32, f); check_eq("s_lsb_L", 64'(f), 64'(F_L));
    idle(1'b0, 2);
    send_word(1'b0, 64'h80000000, 64'h7FFFFFFF, 1'b1, 1'b0, 32, f); check_eq("u_msb_G", 64'(f), 64'(F_G));
    send_word(1'b0, 64'h80000000, 64'h7FFFFFFF, 1'b1, 1'b1, 32, f); check_eq("s_msb_L", 64'(f), 64'(F_L));
    for (int m = 0; m < 4; m++) begin
      send_word(1'b0, 64'hA5A5A5A5, 64'hA5A5A5A5, m[0], m[1], 32, f);
      check_eq("eq_E", 64'(f), 64'(F_E));
    end
    idle(1'b0, 2);

    send_word(1'b0, 64'd5, 64'd9, 1'b0, 1'b0, 10, f);
    send_word(1'b0, 64'd5, 64'd9, 1'b0, 1'b0, 32, f); check_eq("abort_L", 64'(f), 64'(F_L));
    idle(1'b0, 3);
    send_word(1'b0, 64'(32'($urandom)), 64'(32'($urandom)), 1'b0, 1'b0, 20, f);
    do_reset();
    idle(1'b0, 3);

    send_word(1'b1, 64'h80, 64'h7F, 1'b0, 1'b1, 8, f); check_eq("w8_s_L", 64'(f), 64'(F_L));
    idle(1'b1, 1);
    send_word(1'b1, 64'h80, 64'h7F, 1'b0, 1'b0, 8, f); check_eq("w8_u_G", 64'(f), 64'(F_G));
    idle(1'b1, 1);

    for (int t = 0; t < 80; t++) begin
      rsel = 1'($urandom);
      rord = 1'($urandom);
      rsgn = 1'($urandom);
      ra = rsel ? 64'(8'($urandom)) : 64'(32'($urandom));
      rb = ($urandom_range(0, 3) == 0) ? (ra ^ (64'd1 << $urandom_range(0, rsel ? 7 : 31)))
                                       : (rsel ? 64'(8'($urandom)) : 64'(32'($urandom)));
      if ($urandom_range(0, 7) == 0)
        send_word(rsel, ra, rb, rord, rsgn, $urandom_range(1, rsel ? 7 : 31), f);
      send_word(rsel, ra, rb, rord, rsgn, rsel ? 8 : 32, f);
      if ($urandom_range(0, 1) == 0) idle(rsel, $urandom_range(1, 3));
    end
    idle(1'b0, 2);
    idle(1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
